ysyx_23060184_ifu: RTL and testbench
====================================

// Module: ysyx_23060184_ifu
// PURPOSE
//  Instruction fetch unit; receiving end of the PC-stage Pvalid/Iready handshake.
//  Accepts one PC per handshake, issues one single-beat read on an AXI4-Lite-style AR/R channel.
//  Holds the fetched instruction and its PC on a valid/ready output until the decoder accepts them.
//  Sits between the PC register and the IDU in the multi-cycle core.
// PARAMETERS
//  DATA_WIDTH  32  instruction/read-data width
//  ADDR_WIDTH  32  PC/address width
// PORTS
//  clk       in   1           clock, all state updates on posedge
//  rstn      in   1           synchronous active-low reset
//  Pvalid    in   1           PC stage has a valid PC
//  Iready    out  1           IFU can accept a PC
//  PC        in   ADDR_WIDTH  fetch address, sampled on Pvalid&&Iready
//  araddr    out  ADDR_WIDTH  read address
//  arvalid   out  1           read address valid
//  arready   in   1           memory accepts address
//  rdata     in   DATA_WIDTH  read data
//  rresp     in   2           read response, 2'b00 = OKAY
//  rvalid    in   1           read data valid
//  rready    out  1           IFU accepts read data
//  Ivalid    out  1           inst/inst_pc/ifault are valid
//  Dready    in   1           decoder accepts the instruction
//  inst      out  DATA_WIDTH  fetched instruction
//  inst_pc   out  ADDR_WIDTH  PC of inst
//  ifault    out  2           00 none, 01 misaligned PC, 10 bus error
// BEHAVIOUR
//  Reset (rstn=0 at posedge): state=IDLE, Iready=1, arvalid=0, rready=0, Ivalid=0, inst=0, inst_pc=0,
//   ifault=0, araddr=0. Reset mid-transaction abandons it. No outstanding-read tracking.
//  FSM, all outputs registered:
//   IDLE: Iready=1. Pvalid&&Iready latches PC into inst_pc and araddr, drops Iready.
//     If PC[1:0]!=0, go HOLD with inst=0, ifault=01, and no bus access.
//     Otherwise go ADDR with arvalid=1.
//   ADDR: arvalid=1, araddr stable. arvalid&&arready drops arvalid, sets rready=1, goes DATA.
//   DATA: rready=1. rvalid&&rready latches inst<=rdata, sets ifault=(rresp!=0)?10:00.
//     Drops rready, sets Ivalid=1, goes HOLD.
//   HOLD: Ivalid=1 with inst/inst_pc/ifault stable. Ivalid&&Dready drops Ivalid, sets Iready=1, goes IDLE.
//  Minimum latency, zero-wait memory: accept at cycle N; arvalid high in N+1; rready high in N+2;
//   Ivalid high in N+3. A PC is accepted again in the cycle after Dready.
//  Exactly one fetch in flight. Iready=0 in every state except IDLE.
//  Pvalid is ignored outside IDLE. rvalid is ignored outside DATA. arready is ignored outside ADDR.
//  rvalid arriving with arready in the same cycle is not consumed; memory must present R after AR.
//  Any rresp other than OKAY is reported as a bus error; inst still carries rdata.
//  Dready asserted before Ivalid has no effect.
// CONFIGURATION
//  YSYX_23060184_IFU_PERF_EN defined:
//   Adds outputs perf_fetch_cnt [63:0] and perf_stall_cnt [63:0]. Both reset to 0.
//   perf_fetch_cnt increments on each Ivalid&&Dready.
//   perf_stall_cnt increments on each cycle in ADDR or DATA. Both wrap mod 2^64.
//  Undefined: ports and counters absent. Fetch behaviour is identical either way.
// STRUCTURE
//  ysyx_23060184_pkg holds:
//   - ifu_state_t (IDLE/ADDR/DATA/HOLD)
//   - RESP_OKAY=2'b00
//   - IFAULT_NONE/IFAULT_MISALIGN/IFAULT_BUS
//   - RESET_PC=32'h8000_0000, for the PC stage and the bench
//  Sub-module ysyx_23060184_ifu_perf holds the two counters and is instantiated only under the macro.
// TESTING
//  1 Zero-wait memory; PC=0x80000000, rdata=0x00000413, Dready=1 -> Ivalid at N+3, inst=0x00000413,
//    inst_pc=0x80000000, ifault=0.
//  2 arready delayed 3 cycles, rvalid delayed 2 -> araddr held stable while arvalid; Ivalid at N+8;
//    Iready=0 throughout.
//  3 PC=0x80000002 -> no arvalid pulse; Ivalid at N+1 with ifault=01, inst=0.
//  4 rresp=2'b10, rdata=0xDEADBEEF -> ifault=10, inst=0xDEADBEEF; next fetch proceeds normally.
//  5 Dready held low 5 cycles in HOLD -> outputs stable, Iready=0, Pvalid ignored;
//    Iready=1 the cycle after Dready.
//  6 rstn=0 while in DATA -> next cycle all outputs at reset values; new PC accepted immediately;
//    with PERF_EN, counters read 0.

Source files
------------

// File: rtl/ysyx_23060184_pkg.sv
// Shared types and constants for the ysyx_23060184 core front end.
package ysyx_23060184_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StHold
  } ifu_state_t;

  localparam logic [1:0]  RESP_OKAY       = 2'b00;

  localparam logic [1:0]  IFAULT_NONE     = 2'b00;
  localparam logic [1:0]  IFAULT_MISALIGN = 2'b01;
  localparam logic [1:0]  IFAULT_BUS      = 2'b10;

  // First PC after reset; used by the PC stage.
  localparam logic [31:0] RESET_PC        = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060184_ifu_perf.sv
// Fetch performance counters: completed fetches and cycles spent waiting on the bus.
// Instantiated by the IFU only when YSYX_23060184_IFU_PERF_EN is defined.
module ysyx_23060184_ifu_perf (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fetch_done_i,
  input  logic        stall_i,
  output logic [63:0] fetch_cnt_o,
  output logic [63:0] stall_cnt_o
);

  logic [63:0] fetch_cnt_d, fetch_cnt_q;
  logic [63:0] stall_cnt_d, stall_cnt_q;

  // Next-state: increment on each event, wrapping naturally at 2^64.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fetch_done_i) fetch_cnt_d = fetch_cnt_q + 64'd1;
    if (stall_i)      stall_cnt_d = stall_cnt_q + 64'd1;
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/ysyx_23060184_ifu.sv
// Instruction fetch unit: accepts one PC from the PC stage, issues a single-beat AR/R read,
// and holds the instruction on a valid/ready output until the decoder takes it.
// Optional counters enabled by defining YSYX_23060184_IFU_PERF_EN.
module ysyx_23060184_ifu
  import ysyx_23060184_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  Pvalid,
  output logic                  Iready,
  input  logic [ADDR_WIDTH-1:0] PC,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  Ivalid,
  input  logic                  Dready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic [1:0]            ifault
`ifdef YSYX_23060184_IFU_PERF_EN
  ,
  output logic [63:0]           perf_fetch_cnt,
  output logic [63:0]           perf_stall_cnt
`endif
);

  ifu_state_t state_d, state_q;

  logic                  iready_d,  iready_q;
  logic                  arvalid_d, arvalid_q;
  logic                  rready_d,  rready_q;
  logic                  ivalid_d,  ivalid_q;
  logic [ADDR_WIDTH-1:0] araddr_d,  araddr_q;
  logic [ADDR_WIDTH-1:0] inst_pc_d, inst_pc_q;
  logic [DATA_WIDTH-1:0] inst_d,    inst_q;
  logic [1:0]            ifault_d,  ifault_q;

  logic pc_fire, ar_fire, r_fire, i_fire, pc_misaligned;

  // Handshakes only fire in their own state, so stray inputs elsewhere are ignored.
  assign pc_fire       = (state_q == StIdle) && Pvalid && iready_q;
  assign ar_fire       = (state_q == StAddr) && arvalid_q && arready;
  assign r_fire        = (state_q == StData) && rvalid && rready_q;
  assign i_fire        = (state_q == StHold) && ivalid_q && Dready;
  assign pc_misaligned = (PC[1:0] != 2'b00);

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pc_fire) state_d = pc_misaligned ? StHold : StAddr;
      StAddr:  if (ar_fire) state_d = StData;
      StData:  if (r_fire)  state_d = StHold;
      StHold:  if (i_fire)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs; everything holds unless a handshake fires.
  always_comb begin
    iready_d  = iready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    ivalid_d  = ivalid_q;
    araddr_d  = araddr_q;
    inst_pc_d = inst_pc_q;
    inst_d    = inst_q;
    ifault_d  = ifault_q;
    unique case (state_q)
      StIdle: begin
        if (pc_fire) begin
          iready_d  = 1'b0;
          araddr_d  = PC;
          inst_pc_d = PC;
          if (pc_misaligned) begin
            // Skip the bus entirely and report the fault straight away.
            inst_d   = '0;
            ifault_d = IFAULT_MISALIGN;
            ivalid_d = 1'b1;
          end else begin
            arvalid_d = 1'b1;
          end
        end
      end
      StAddr: begin
        if (ar_fire) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      StData: begin
        if (r_fire) begin
          inst_d   = rdata;
          ifault_d = (rresp != RESP_OKAY) ? IFAULT_BUS : IFAULT_NONE;
          rready_d = 1'b0;
          ivalid_d = 1'b1;
        end
      end
      StHold: begin
        if (i_fire) begin
          ivalid_d = 1'b0;
          iready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output registers; reset abandons any in-flight read.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      iready_q  <= 1'b1;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ivalid_q  <= 1'b0;
      araddr_q  <= '0;
      inst_pc_q <= '0;
      inst_q    <= '0;
      ifault_q  <= IFAULT_NONE;
    end else begin
      iready_q  <= iready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ivalid_q  <= ivalid_d;
      araddr_q  <= araddr_d;
      inst_pc_q <= inst_pc_d;
      inst_q    <= inst_d;
      ifault_q  <= ifault_d;
    end
  end

  assign Iready  = iready_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign Ivalid  = ivalid_q;
  assign araddr  = araddr_q;
  assign inst_pc = inst_pc_q;
  assign inst    = inst_q;
  assign ifault  = ifault_q;

`ifdef YSYX_23060184_IFU_PERF_EN
  ysyx_23060184_ifu_perf u_perf (
    .clk          (clk),
    .rstn         (rstn),
    .fetch_done_i (i_fire),
    .stall_i      ((state_q == StAddr) || (state_q == StData)),
    .fetch_cnt_o  (perf_fetch_cnt),
    .stall_cnt_o  (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_ysyx_23060184_ifu.sv
// Directed self-checking bench for ysyx_23060184_ifu.
module tb_ysyx_23060184_ifu;
  import ysyx_23060184_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        Pvalid;
  logic        Iready;
  logic [31:0] PC;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        Ivalid;
  logic        Dready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [1:0]  ifault;
`ifdef YSYX_23060184_IFU_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ysyx_23060184_ifu #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .Pvalid  (Pvalid),
    .Iready  (Iready),
    .PC      (PC),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .Ivalid  (Ivalid),
    .Dready  (Dready),
    .inst    (inst),
    .inst_pc (inst_pc),
    .ifault  (ifault)
`ifdef YSYX_23060184_IFU_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one clock and settle past the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".Iready"},  64'(Iready),  64'd1);
    check({tag, ".arvalid"}, 64'(arvalid), 64'd0);
    check({tag, ".rready"},  64'(rready),  64'd0);
    check({tag, ".Ivalid"},  64'(Ivalid),  64'd0);
    check({tag, ".inst"},    64'(inst),    64'd0);
    check({tag, ".inst_pc"}, 64'(inst_pc), 64'd0);
    check({tag, ".ifault"},  64'(ifault),  64'd0);
    check({tag, ".araddr"},  64'(araddr),  64'd0);
`ifdef YSYX_23060184_IFU_PERF_EN
    check({tag, ".perf_fetch"}, perf_fetch_cnt, 64'd0);
    check({tag, ".perf_stall"}, perf_stall_cnt, 64'd0);
`endif
  endtask

  // Present a PC for one cycle; returns in the cycle after acceptance.
  task automatic accept_pc(input logic [31:0] pc);
    Pvalid = 1'b1;
    PC     = pc;
    step();
    Pvalid = 1'b0;
  endtask

  initial begin
    rstn    = 1'b0;
    Pvalid  = 1'b0;
    PC      = '0;
    arready = 1'b0;
    rdata   = '0;
    rresp   = 2'b00;
    rvalid  = 1'b0;
    Dready  = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    rstn = 1'b1;

    // 1: zero-wait memory, minimum latency.
    arready = 1'b1;
    rvalid  = 1'b1;
    rdata   = 32'h0000_0413;
    Dready  = 1'b1;
    accept_pc(RESET_PC);
    check("t1.arvalid_n1", 64'(arvalid), 64'd1);
    check("t1.araddr_n1",  64'(araddr),  64'h8000_0000);
    check("t1.iready_n1",  64'(Iready),  64'd0);
    step();
    check("t1.rready_n2",  64'(rready),  64'd1);
    check("t1.arvalid_n2", 64'(arvalid), 64'd0);
    check("t1.ivalid_n2",  64'(Ivalid),  64'd0);
    step();
    check("t1.ivalid_n3",  64'(Ivalid),  64'd1);
    check("t1.inst",       64'(inst),    64'h0000_0413);
    check("t1.inst_pc",    64'(inst_pc), 64'h8000_0000);
    check("t1.ifault",     64'(ifault),  64'(IFAULT_NONE));
    check("t1.rready_n3",  64'(rready),  64'd0);
    step();
    check("t1.ivalid_done", 64'(Ivalid), 64'd0);
    check("t1.iready_back", 64'(Iready), 64'd1);
`ifdef YSYX_23060184_IFU_PERF_EN
    check("t1.perf_fetch", perf_fetch_cnt, 64'd1);
    check("t1.perf_stall", perf_stall_cnt, 64'd2);
`endif

    // 2: arready delayed 3 cycles, rvalid delayed 2; Pvalid with a new PC must be ignored.
    arready = 1'b0;
    rvalid  = 1'b0;
    rdata   = 32'h0010_0093;
    accept_pc(32'h8000_0010);
    Pvalid = 1'b1;
    PC     = 32'h1234_5678;
    check("t2.arvalid_n1", 64'(arvalid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2.arvalid_wait", 64'(arvalid), 64'd1);
      check("t2.araddr_wait",  64'(araddr),  64'h8000_0010);
      check("t2.iready_wait",  64'(Iready),  64'd0);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("t2.rready_n5",  64'(rready),  64'd1);
    check("t2.arvalid_n5", 64'(arvalid), 64'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("t2.rready_wait", 64'(rready), 64'd1);
      check("t2.ivalid_wait", 64'(Ivalid), 64'd0);
      check("t2.iready_wait", 64'(Iready), 64'd0);
    end
    rvalid = 1'b1;
    step();
    rvalid = 1'b0;
    Pvalid = 1'b0;
    check("t2.ivalid_n8", 64'(Ivalid),  64'd1);
    check("t2.inst",      64'(inst),    64'h0010_0093);
    check("t2.inst_pc",   64'(inst_pc), 64'h8000_0010);
    check("t2.iready_n8", 64'(Iready),  64'd0);
    step();
    check("t2.iready_back", 64'(Iready), 64'd1);

    // 3: misaligned PC faults without touching the bus.
    accept_pc(32'h8000_0002);
    check("t3.arvalid", 64'(arvalid), 64'd0);
    check("t3.ivalid",  64'(Ivalid),  64'd1);
    check("t3.ifault",  64'(ifault),  64'(IFAULT_MISALIGN));
    check("t3.inst",    64'(inst),    64'd0);
    check("t3.inst_pc", 64'(inst_pc), 64'h8000_0002);
    step();
    check("t3.iready_back", 64'(Iready), 64'd1);
    check("t3.arvalid_after", 64'(arvalid), 64'd0);

    // 4: error response, then a clean fetch.
    arready = 1'b1;
    rvalid  = 1'b1;
    rresp   = 2'b10;
    rdata   = 32'hDEAD_BEEF;
    accept_pc(32'h8000_0004);
    step();
    step();
    check("t4.ivalid", 64'(Ivalid), 64'd1);
    check("t4.ifault", 64'(ifault), 64'(IFAULT_BUS));
    check("t4.inst",   64'(inst),   64'hDEAD_BEEF);
    step();
    rresp = RESP_OKAY;
    rdata = 32'h0000_0013;
    accept_pc(32'h8000_0008);
    check("t4b.araddr", 64'(araddr), 64'h8000_0008);
    step();
    step();
    check("t4b.ivalid", 64'(Ivalid), 64'd1);
    check("t4b.ifault", 64'(ifault), 64'(IFAULT_NONE));
    check("t4b.inst",   64'(inst),   64'h0000_0013);
    step();

    // 5: decoder back-pressure in HOLD.
    Dready = 1'b0;
    rdata  = 32'h0050_0113;
    accept_pc(32'h8000_000C);
    step();
    step();
    check("t5.ivalid", 64'(Ivalid), 64'd1);
    Pvalid = 1'b1;
    PC     = 32'h8000_0100;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5.ivalid_hold",  64'(Ivalid),  64'd1);
      check("t5.iready_hold",  64'(Iready),  64'd0);
      check("t5.inst_hold",    64'(inst),    64'h0050_0113);
      check("t5.inst_pc_hold", 64'(inst_pc), 64'h8000_000C);
      check("t5.arvalid_hold", 64'(arvalid), 64'd0);
    end
    Pvalid = 1'b0;
    Dready = 1'b1;
    step();
    check("t5.ivalid_done", 64'(Ivalid), 64'd0);
    check("t5.iready_back", 64'(Iready), 64'd1);

    // 6: reset while waiting in DATA.
    arready = 1'b1;
    rvalid  = 1'b0;
    accept_pc(32'h8000_0014);
    step();
    check("t6.rready_data", 64'(rready), 64'd1);
    rstn = 1'b0;
    step();
    check_reset_outputs("t6.reset");
    rstn = 1'b1;
    accept_pc(32'h8000_0020);
    check("t6.arvalid_new", 64'(arvalid), 64'd1);
    check("t6.araddr_new",  64'(araddr),  64'h8000_0020);
    check("t6.iready_new",  64'(Iready),  64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
